// File: rtl/ham_pkg.sv
// Shared Hamming (15,11) definitions: codeword geometry, scrubber FSM states and
// the syndrome function used by any block that checks stored codewords.
package ham_pkg;

    localparam int HAM_W  = 15;
    localparam int HAM_DW = 11;
    localparam int HAM_PW = HAM_W - HAM_DW;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RD,
        ST_RDW,
        ST_CHK,
        ST_WR,
        ST_NXT
    } state_e;

    // Syndrome bit k is the parity of every codeword bit whose 1-based position has bit k set.
    function automatic logic [HAM_PW-1:0] ham_15_11_syndrome(input logic [HAM_W-1:0] cw);
        logic [HAM_PW-1:0] syn;
        logic [HAM_PW-1:0] pos;
        syn = '0;
        for (int p = 0; p < HAM_W; p++) begin
            pos = HAM_PW'(p + 1);
            for (int k = 0; k < HAM_PW; k++) begin
                if (pos[k]) begin
                    syn[k] = syn[k] ^ cw[p];
                end
            end
        end
        return syn;
    endfunction

endpackage

// File: rtl/ham_15_11_fix.sv
// Combinational single-error corrector for Hamming (15,11): reports the syndrome
// and the codeword with bit (syndrome-1) flipped when the syndrome is non-zero.
module ham_15_11_fix
    import ham_pkg::*;
(
    input  logic [HAM_W-1:0]  cw_i,
    output logic [HAM_PW-1:0] syn_o,
    output logic [HAM_W-1:0]  cw_o
);

    logic [HAM_PW-1:0] syn;

    assign syn   = ham_15_11_syndrome(cw_i);
    assign syn_o = syn;
    assign cw_o  = (syn == '0) ? cw_i : (cw_i ^ (HAM_W'(1) << (syn - HAM_PW'(1))));

endmodule

// File: rtl/ham_15_11_scrubber.sv
// Background scrubber: sweeps every word, checks it and (with HAM_SCRUB_WRITEBACK_EN
// defined) writes corrected words back under an arbiter lock; otherwise detect-only.
module ham_15_11_scrubber
    import ham_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16,
    parameter int IVL_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              continuous_i,
    input  logic [IVL_W-1:0]  interval_i,
    input  logic              clr_cnt_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [14:0]       mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic [14:0]       mem_rdata_i,
    input  logic              mem_rvalid_i,
    output logic              mem_lock_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  err_cnt_o,
    output logic [ADDR_W-1:0] last_addr_o,
    output logic [3:0]        last_syn_o
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [IVL_W-1:0]  ivl_q;
    logic [HAM_W-1:0]  data_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] last_addr_q;
    logic [HAM_PW-1:0] last_syn_q;
    logic [HAM_PW-1:0] syn;
    logic [HAM_W-1:0]  fixed;
    logic              last_word;
    logic              fix_hit;
    state_e            go_state;

    ham_15_11_fix u_fix (
        .cw_i  (data_q),
        .syn_o (syn),
        .cw_o  (fixed)
    );

    assign last_word = (addr_q == '1);
    assign fix_hit   = (state_q == ST_CHK) && (syn != '0);
    // A zero interval skips WAIT entirely so a clean word costs exactly four cycles.
    assign go_state  = (interval_i == '0) ? ST_RD : ST_WAIT;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_i) state_d = go_state;
            ST_WAIT: if (ivl_q <= IVL_W'(1)) state_d = ST_RD;
            ST_RD:   if (mem_gnt_i) state_d = ST_RDW;
            ST_RDW:  if (mem_rvalid_i) state_d = ST_CHK;
`ifdef HAM_SCRUB_WRITEBACK_EN
            ST_CHK:  state_d = (syn != '0) ? ST_WR : ST_NXT;
            ST_WR:   if (mem_gnt_i) state_d = ST_NXT;
`else
            ST_CHK:  state_d = ST_NXT;
`endif
            ST_NXT:  state_d = (!last_word || continuous_i) ? go_state : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_req_o = (state_q == ST_RD) || (state_q == ST_WR);
        mem_we_o  = 1'b0;
`ifdef HAM_SCRUB_WRITEBACK_EN
        mem_we_o  = (state_q == ST_WR);
`endif
        busy_o    = (state_q != ST_IDLE);
        done_o    = (state_q == ST_NXT) && last_word;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            addr_q      <= '0;
            ivl_q       <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
            last_addr_q <= '0;
            last_syn_q  <= '0;
        end else begin
            if (state_d == ST_WAIT && state_q != ST_WAIT) begin
                ivl_q <= interval_i;
            end else if (state_q == ST_WAIT) begin
                ivl_q <= ivl_q - IVL_W'(1);
            end
            if (state_q == ST_NXT) begin
                addr_q <= addr_q + ADDR_W'(1);
            end
            if (state_q == ST_RDW && mem_rvalid_i) begin
                data_q <= mem_rdata_i;
            end
            // Clear has priority over a same-cycle correction.
            if (clr_cnt_i) begin
                cnt_q <= '0;
            end else if (fix_hit && cnt_q != '1) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (fix_hit) begin
                last_addr_q <= addr_q;
                last_syn_q  <= syn;
            end
        end
    end

`ifdef HAM_SCRUB_WRITEBACK_EN
    logic             lock_q;
    logic [HAM_W-1:0] wdata_q;

    // Lock spans read grant to write grant so no user write lands mid read-modify-write.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lock_q  <= 1'b0;
            wdata_q <= '0;
        end else begin
            if (state_q == ST_RD && mem_gnt_i) begin
                lock_q <= 1'b1;
            end else if ((state_q == ST_CHK && syn == '0) || (state_q == ST_WR && mem_gnt_i)) begin
                lock_q <= 1'b0;
            end
            if (state_q == ST_CHK) begin
                wdata_q <= fixed;
            end
        end
    end

    assign mem_lock_o  = lock_q;
    assign mem_wdata_o = wdata_q;
`else
    logic unused_fix;
    assign unused_fix  = ^fixed;
    assign mem_lock_o  = 1'b0;
    assign mem_wdata_o = '0;
`endif

    assign mem_addr_o  = addr_q;
    assign err_cnt_o   = cnt_q;
    assign last_addr_o = last_addr_q;
    assign last_syn_o  = last_syn_q;

endmodule

// File: tb/tb_ham_15_11_scrubber.sv
// Directed bench for ham_15_11_scrubber with a 4-word memory and a simple arbiter
// model; write-back expectations follow HAM_SCRUB_WRITEBACK_EN.
module tb_ham_15_11_scrubber;

    localparam int ADDR_W = 2;
    localparam int CNT_W  = 2;
    localparam int IVL_W  = 16;

    logic              clk_i = 1'b0;
    logic              rst_n_i;
    logic              start_i;
    logic              continuous_i;
    logic [IVL_W-1:0]  interval_i;
    logic              clr_cnt_i;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [14:0]       mem_wdata_o;
    logic              mem_gnt_i;
    logic [14:0]       mem_rdata_i;
    logic              mem_rvalid_i;
    logic              mem_lock_o;
    logic              busy_o;
    logic              done_o;
    logic [CNT_W-1:0]  err_cnt_o;
    logic [ADDR_W-1:0] last_addr_o;
    logic [3:0]        last_syn_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Memory / arbiter model state (owned by the negedge process).
    logic [14:0] mem      [4];
    logic [14:0] init_mem [4];
    int          load_seq  = 0;
    int          load_seen = 0;
    int          cyc = 0, n_rd = 0, n_wr = 0, n_done = 0;
    int          rd_cyc_q[$];
    int          rd_addr_q[$];
    int          wr_addr_q[$];
    logic [14:0] wr_data_q[$];
    bit          pend = 1'b0;
    logic [14:0] pend_data = '0;
    bit          lock_seen = 1'b0;
    bit          we_seen = 1'b0;

    ham_15_11_scrubber #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .IVL_W(IVL_W)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .start_i      (start_i),
        .continuous_i (continuous_i),
        .interval_i   (interval_i),
        .clr_cnt_i    (clr_cnt_i),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rdata_i  (mem_rdata_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_lock_o   (mem_lock_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_cnt_o    (err_cnt_o),
        .last_addr_o  (last_addr_o),
        .last_syn_o   (last_syn_o)
    );

    always #5 clk_i = ~clk_i;

    // Outputs are stable at the falling edge; a req&gnt seen here is consumed at the next rising edge.
    always @(negedge clk_i) begin
        cyc++;
        mem_rvalid_i = pend;
        mem_rdata_i  = pend ? pend_data : 15'h0;
        pend = 1'b0;
        if (load_seq != load_seen) begin
            for (int i = 0; i < 4; i++) mem[i] = init_mem[i];
            load_seen = load_seq;
        end
        if (!rst_n_i) begin
            mem_rvalid_i = 1'b0;
        end else begin
            if (done_o) n_done++;
            if (mem_lock_o) lock_seen = 1'b1;
            if (mem_we_o) we_seen = 1'b1;
            if (mem_req_o && mem_gnt_i) begin
                if (mem_we_o) begin
                    mem[mem_addr_o] = mem_wdata_o;
                    n_wr++;
                    wr_addr_q.push_back(int'(mem_addr_o));
                    wr_data_q.push_back(mem_wdata_o);
                end else begin
                    pend      = 1'b1;
                    pend_data = mem[mem_addr_o];
                    n_rd++;
                    rd_cyc_q.push_back(cyc);
                    rd_addr_q.push_back(int'(mem_addr_o));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic load_mem(input logic [14:0] w0, input logic [14:0] w1,
                            input logic [14:0] w2, input logic [14:0] w3);
        init_mem[0] = w0;
        init_mem[1] = w1;
        init_mem[2] = w2;
        init_mem[3] = w3;
        load_seq++;
        tick();
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (!busy_o) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({mem_req_o, mem_we_o, mem_lock_o, busy_o, done_o} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b exp 00000", {mem_req_o, mem_we_o, mem_lock_o, busy_o, done_o});
        end
        n_checks++;
        if ({err_cnt_o, last_addr_o, last_syn_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_log got cnt=%0d addr=%0d syn=%0d exp all 0", err_cnt_o, last_addr_o, last_syn_o);
        end
        n_checks++;
        if ({mem_addr_o, mem_wdata_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_bus got addr=%0d wdata=%h exp 0", mem_addr_o, mem_wdata_o);
        end
        rst_n_i = 1'b1;
        tick();
    endtask

    task automatic test_clean_sweep();
        int rb, wb, db, qb;
        bit ok;
        load_mem(15'h0000, 15'h7FFF, 15'h0007, 15'h0019);
        rb = n_rd; wb = n_wr; db = n_done; qb = rd_cyc_q.size();
        pulse_start();
        n_checks++;
        if (busy_o !== 1'b1) begin n_fail++; $display("FAIL clean_busy_rise got %b exp 1", busy_o); end
        wait_idle(100, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL clean_timeout got busy=%b exp 0", busy_o); end
        n_checks++;
        if (n_rd - rb != 4 || n_wr - wb != 0) begin
            n_fail++;
            $display("FAIL clean_access got rd=%0d wr=%0d exp rd=4 wr=0", n_rd - rb, n_wr - wb);
        end
        n_checks++;
        if (n_done - db != 1) begin n_fail++; $display("FAIL clean_done got %0d exp 1", n_done - db); end
        n_checks++;
        if (err_cnt_o !== 2'd0) begin n_fail++; $display("FAIL clean_cnt got %0d exp 0", err_cnt_o); end
        for (int i = 1; i < 4; i++) begin
            n_checks++;
            if (rd_cyc_q.size() < qb + 4 || rd_cyc_q[qb+i] - rd_cyc_q[qb+i-1] != 4 || rd_addr_q[qb+i] != i) begin
                n_fail++;
                $display("FAIL clean_word_%0d got period/addr mismatch exp period 4 addr %0d", i, i);
            end
        end
    endtask

    task automatic test_single_error();
        int wb, qb, exp_per;
        bit ok;
        load_mem(15'h0000, 15'h7FFF, 15'h0047, 15'h0019);
        wb = n_wr; qb = rd_cyc_q.size();
        pulse_start();
        wait_idle(100, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL single_timeout got busy=%b exp 0", busy_o); end
        n_checks++;
        if (err_cnt_o !== 2'd1 || last_addr_o !== 2'd2 || last_syn_o !== 4'd7) begin
            n_fail++;
            $display("FAIL single_log got cnt=%0d addr=%0d syn=%0d exp 1 2 7", err_cnt_o, last_addr_o, last_syn_o);
        end
`ifdef HAM_SCRUB_WRITEBACK_EN
        exp_per = 5;
        n_checks++;
        if (n_wr - wb != 1 || wr_addr_q[wr_addr_q.size()-1] != 2 || wr_data_q[wr_data_q.size()-1] !== 15'h0007) begin
            n_fail++;
            $display("FAIL single_write got n=%0d exp one write 0007 to addr 2", n_wr - wb);
        end
        n_checks++;
        if (mem[2] !== 15'h0007) begin n_fail++; $display("FAIL single_mem got %h exp 0007", mem[2]); end
`else
        exp_per = 4;
        n_checks++;
        if (n_wr - wb != 0 || we_seen || lock_seen) begin
            n_fail++;
            $display("FAIL single_detect_only got wr=%0d we=%b lock=%b exp 0 0 0", n_wr - wb, we_seen, lock_seen);
        end
        n_checks++;
        if (mem[2] !== 15'h0047) begin n_fail++; $display("FAIL single_mem got %h exp 0047", mem[2]); end
`endif
        n_checks++;
        if (rd_cyc_q.size() < qb + 4 || rd_cyc_q[qb+3] - rd_cyc_q[qb+2] != exp_per) begin
            n_fail++;
            $display("FAIL single_period exp %0d cycles for corrected word", exp_per);
        end
    endtask

    task automatic test_grant_stall();
        bit ok;
        load_mem(15'h0008, 15'h7FFF, 15'h0007, 15'h0019);
        mem_gnt_i = 1'b0;
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 2'd0 || mem_lock_o !== 1'b0) begin
                n_fail++;
                $display("FAIL rd_stall_%0d got req=%b we=%b addr=%0d lock=%b exp 1 0 0 0",
                         i, mem_req_o, mem_we_o, mem_addr_o, mem_lock_o);
            end
            tick();
        end
        mem_gnt_i = 1'b1;
`ifdef HAM_SCRUB_WRITEBACK_EN
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (mem_req_o && mem_we_o) ok = 1'b1;
        end
        mem_gnt_i = 1'b0;
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL wr_reach got no write request exp one"); end
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 2'd0 ||
                mem_wdata_o !== 15'h0000 || mem_lock_o !== 1'b1) begin
                n_fail++;
                $display("FAIL wr_stall_%0d got req=%b we=%b addr=%0d wdata=%h lock=%b exp 1 1 0 0000 1",
                         i, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_lock_o);
            end
            tick();
        end
        mem_gnt_i = 1'b1;
`endif
        wait_idle(100, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL stall_timeout got busy=%b exp 0", busy_o); end
        n_checks++;
        if (err_cnt_o !== 2'd2 || last_addr_o !== 2'd0 || last_syn_o !== 4'd4) begin
            n_fail++;
            $display("FAIL stall_log got cnt=%0d addr=%0d syn=%0d exp 2 0 4", err_cnt_o, last_addr_o, last_syn_o);
        end
        n_checks++;
`ifdef HAM_SCRUB_WRITEBACK_EN
        if (mem[0] !== 15'h0000 || mem_lock_o !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_mem got mem0=%h lock=%b exp 0000 0", mem[0], mem_lock_o);
        end
`else
        if (mem[0] !== 15'h0008 || lock_seen || we_seen) begin
            n_fail++;
            $display("FAIL stall_mem got mem0=%h lock_seen=%b we_seen=%b exp 0008 0 0", mem[0], lock_seen, we_seen);
        end
`endif
    endtask

    task automatic test_saturation();
        bit ok;
        clr_cnt_i = 1'b1;
        tick();
        clr_cnt_i = 1'b0;
        n_checks++;
        if (err_cnt_o !== 2'd0) begin n_fail++; $display("FAIL sat_clear got %0d exp 0", err_cnt_o); end
        load_mem(15'h0001, 15'h7FFD, 15'h0003, 15'h0009);
        pulse_start();
        wait_idle(100, ok);
        n_checks++;
        if (!ok || err_cnt_o !== 2'd3 || last_addr_o !== 2'd3 || last_syn_o !== 4'd5) begin
            n_fail++;
            $display("FAIL sat_four got cnt=%0d addr=%0d syn=%0d exp 3 3 5", err_cnt_o, last_addr_o, last_syn_o);
        end
`ifdef HAM_SCRUB_WRITEBACK_EN
        n_checks++;
        if ({mem[0], mem[1], mem[2], mem[3]} !== {15'h0000, 15'h7FFF, 15'h0007, 15'h0019}) begin
            n_fail++;
            $display("FAIL sat_mem got %h %h %h %h exp 0000 7fff 0007 0019", mem[0], mem[1], mem[2], mem[3]);
        end
`endif
        load_mem(15'h0000, 15'h7FFF, 15'h0003, 15'h0019);
        pulse_start();
        wait_idle(100, ok);
        n_checks++;
        if (!ok || err_cnt_o !== 2'd3 || last_addr_o !== 2'd2 || last_syn_o !== 4'd3) begin
            n_fail++;
            $display("FAIL sat_fifth got cnt=%0d addr=%0d syn=%0d exp 3 2 3", err_cnt_o, last_addr_o, last_syn_o);
        end
    endtask

    task automatic test_clr_collision();
        bit ok, found;
        load_mem(15'h0000, 15'h7FFE, 15'h0007, 15'h0019);
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (mem_req_o && !mem_we_o && mem_addr_o == 2'd1) found = 1'b1;
            else tick();
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL clr_reach got no read of addr 1 exp one"); end
        tick();
        tick();
        clr_cnt_i = 1'b1;
        tick();
        clr_cnt_i = 1'b0;
        n_checks++;
        if (err_cnt_o !== 2'd0 || last_addr_o !== 2'd1 || last_syn_o !== 4'd1) begin
            n_fail++;
            $display("FAIL clr_collide got cnt=%0d addr=%0d syn=%0d exp 0 1 1", err_cnt_o, last_addr_o, last_syn_o);
        end
        wait_idle(100, ok);
        n_checks++;
        if (!ok || err_cnt_o !== 2'd0) begin
            n_fail++;
            $display("FAIL clr_after got cnt=%0d busy=%b exp 0 0", err_cnt_o, busy_o);
        end
    endtask

    task automatic test_continuous();
        int qb, db, rb;
        bit ok;
        load_mem(15'h0000, 15'h7FFF, 15'h0007, 15'h0019);
        continuous_i = 1'b1;
        interval_i   = 16'd3;
        qb = rd_cyc_q.size(); db = n_done; rb = n_rd;
        pulse_start();
        for (int i = 0; i < 9; i++) tick();
        pulse_start();
        for (int i = 0; i < 200 && (n_rd - rb) < 6; i++) tick();
        continuous_i = 1'b0;
        wait_idle(200, ok);
        n_checks++;
        if (!ok || n_rd - rb != 8 || n_done - db != 2) begin
            n_fail++;
            $display("FAIL cont_count got rd=%0d done=%0d exp 8 2", n_rd - rb, n_done - db);
        end
        for (int i = 1; i < 8; i++) begin
            n_checks++;
            if (rd_cyc_q.size() < qb + 8 || rd_cyc_q[qb+i] - rd_cyc_q[qb+i-1] != 7 || rd_addr_q[qb+i] != (i % 4)) begin
                n_fail++;
                $display("FAIL cont_word_%0d exp period 7 addr %0d", i, i % 4);
            end
        end
        interval_i = '0;
    endtask

    task automatic test_reset_mid_access();
        int rb;
        bit ok, found;
        load_mem(15'h0000, 15'h7FFE, 15'h0007, 15'h0019);
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
`ifdef HAM_SCRUB_WRITEBACK_EN
            if (mem_req_o && mem_we_o) found = 1'b1;
`else
            if (mem_req_o && mem_addr_o == 2'd1) found = 1'b1;
`endif
            else tick();
        end
        mem_gnt_i = 1'b0;
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL rst_reach got no target access exp one"); end
        tick();
        rst_n_i = 1'b0;
        #1;
        n_checks++;
        if (mem_req_o !== 1'b0 || mem_lock_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async got req=%b lock=%b busy=%b exp 0 0 0", mem_req_o, mem_lock_o, busy_o);
        end
        tick();
        rst_n_i   = 1'b1;
        mem_gnt_i = 1'b1;
        rb = n_rd;
        for (int i = 0; i < 20; i++) tick();
        n_checks++;
        if (busy_o !== 1'b0 || mem_req_o !== 1'b0 || n_rd != rb || err_cnt_o !== 2'd0) begin
            n_fail++;
            $display("FAIL rst_idle got busy=%b req=%b reads=%0d cnt=%0d exp 0 0 0 0",
                     busy_o, mem_req_o, n_rd - rb, err_cnt_o);
        end
        pulse_start();
        wait_idle(100, ok);
        n_checks++;
        if (!ok || err_cnt_o !== 2'd1 || last_addr_o !== 2'd1) begin
            n_fail++;
            $display("FAIL rst_restart got cnt=%0d addr=%0d exp 1 1", err_cnt_o, last_addr_o);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got no finish exp finish");
        $fatal(1);
    end

    initial begin
        rst_n_i      = 1'b0;
        start_i      = 1'b0;
        continuous_i = 1'b0;
        interval_i   = '0;
        clr_cnt_i    = 1'b0;
        mem_gnt_i    = 1'b1;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        test_reset();
        test_clean_sweep();
        test_single_error();
        test_grant_stall();
        test_saturation();
        test_clr_collision();
        test_continuous();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ham_15_11_scrubber.md
# ham_15_11_scrubber

Background scrubber for memories that store Hamming (15,11) codewords (bit order {D11..D5, P8, D4..D2, P4, D1, P2, P1}). It sweeps the array one word at a time, computes the 4-bit syndrome, and writes the corrected codeword back when a single-bit error is found. It counts the corrections and records the most recent one. It shares the memory port with user logic through an external arbiter, and sits in front of the SEC decoder that serves user reads, so user reads see freshly scrubbed words.

## Interface
- ADDR_W, 8, memory address width; the sweep covers 2^ADDR_W words
- CNT_W, 16, width of the correction counter
- IVL_W, 16, width of the inter-word idle interval
- clk_i  in  1  clock
- rst_n_i  in  1  reset; asynchronous, active-low
- start_i  in  1  single-cycle pulse that starts a sweep; ignored while busy_o=1
- continuous_i  in  1  when high at end of sweep, the next sweep starts automatically
- interval_i  in  IVL_W  idle cycles inserted before each word access
- clr_cnt_i  in  1  synchronous clear of err_cnt_o
- mem_req_o  out  1  memory access request
- mem_we_o  out  1  write qualifier, valid with mem_req_o
- mem_addr_o  out  ADDR_W  access address
- mem_wdata_o  out  15  corrected codeword
- mem_gnt_i  in  1  arbiter grant; the access is consumed in the cycle req&gnt
- mem_rdata_i  in  15  read data, valid with mem_rvalid_i
- mem_rvalid_i  in  1  read data valid, one or more cycles after a read grant
- mem_lock_o  out  1  asks the arbiter to block user writes during read-modify-write
- busy_o  out  1  a sweep is in progress
- done_o  out  1  one-cycle pulse when a sweep completes
- err_cnt_o  out  CNT_W  corrected-word count, saturating
- last_addr_o  out  ADDR_W  address of the last corrected word
- last_syn_o  out  4  syndrome of the last corrected word

## Operation
- FSM states: IDLE, WAIT, RD, RDW, CHK, WR, NXT.
- IDLE → WAIT on start_i.
- WAIT: loads a counter with interval_i and decrements it. Moves to RD when the counter reaches 0. interval_i=0 means zero idle cycles.
- RD: mem_req_o=1, mem_we_o=0. Request is held until mem_gnt_i. On grant, mem_lock_o is set and the state moves to RDW.
- RDW: on mem_rvalid_i, registers mem_rdata_i and moves to CHK.
- CHK: computes the syndrome. Syndrome bit k is the XOR of all codeword bits at index p where (p+1) has bit k set.
  - Syndrome 0: mem_lock_o cleared, go to NXT.
  - Syndrome s≠0: flip bit s−1; err_cnt_o+1 (saturating at all-ones); last_addr_o and last_syn_o updated; go to WR.
- WR: mem_req_o=1, mem_we_o=1, mem_wdata_o = corrected word. Held until grant. On grant, mem_lock_o cleared, go to NXT.
- NXT:
  - If the address is not the last one: address+1, go to WAIT.
  - At the last address (2^ADDR_W−1): address wraps to 0 and done_o pulses. If continuous_i=1, go to WAIT; otherwise go to IDLE.
- mem_addr_o holds the current address through the whole read-modify-write.
- If clr_cnt_i and an increment occur in the same cycle, the clear wins and err_cnt_o=0.
- A start_i pulse that arrives while busy_o=1 is dropped, not queued.
- A double error aliases to a wrong single-bit correction. This is accepted SEC behaviour.

## Timing
- Reset values: all outputs 0; FSM in IDLE; address 0.
- Reset asserted mid-access: mem_req_o and mem_lock_o drop asynchronously. The access in flight is abandoned, and any data returned afterwards is ignored.
- busy_o is high in every state except IDLE. It rises in the cycle after start_i.
- Cycle counts per word, with grant and rvalid arriving immediately:
  - Clean word: interval + 4 cycles (WAIT exit, RD, RDW, CHK, NXT merged as specified).
  - Corrected word: interval + 5 cycles.
- Grant is sampled every cycle; the number of wait cycles for grant is unbounded.
- Syndrome logic runs on registered data, so the only combinational path is register → syndrome → register.

## Configuration
- HAM_SCRUB_WRITEBACK_EN defined: full behaviour as above.
- HAM_SCRUB_WRITEBACK_EN undefined (detect-only mode):
  - The WR state is removed; CHK always goes to NXT.
  - mem_we_o, mem_wdata_o and mem_lock_o are tied to 0.
  - Counting and logging are unchanged.

## Structure
- Package ham_pkg:
  - HAM_W=15 and HAM_DW=11 constants
  - FSM state enum
  - function ham_15_11_syndrome(codeword) → 4 bits
- Sub-module ham_15_11_fix: combinational; takes the codeword and returns the syndrome and the corrected codeword. It is instantiated in CHK and can be reused by future blocks.

## Test plan
- ADDR_W=2, memory preloaded with clean codewords, start_i → four reads and no writes; done_o pulses once; err_cnt_o=0; busy_o returns to 0.
- Word at address 2 has bit 6 flipped (syndrome 7) → one write to address 2 with bit 6 restored; err_cnt_o=1, last_addr_o=2, last_syn_o=7.
- mem_gnt_i held low for 10 cycles during RD and again during WR → mem_req_o, address and data stay stable; mem_lock_o stays high from read grant to write grant.
- CNT_W=2, errors injected in 5 words → err_cnt_o saturates at 3. clr_cnt_i in the same cycle as an increment → err_cnt_o=0.
- continuous_i=1, interval_i=3 → a second sweep starts with no new start_i; exactly 3 idle cycles between words; a start_i pulse during the sweep has no effect.
- rst_n_i asserted while in WR → mem_req_o=0 immediately; the scrubber stays in IDLE until the next start_i.
